// File: rtl/ppwm_core.sv
// Programmable PWM execution core: fetches one 8-bit instruction per cycle and
// updates a working duty register, a scratch register and a compare flag.
package ppwm_pkg;
    typedef enum logic [2:0] {
        CMD_CTRL   = 3'd0,
        CMD_SET    = 3'd1,
        CMD_ARITH  = 3'd2,
        CMD_SHIFT  = 3'd3,
        CMD_RSRV   = 3'd4,
        CMD_JUMP   = 3'd5,
        CMD_CMP    = 3'd6,
        CMD_BRANCH = 3'd7
    } command_e;

    typedef enum logic {
        TGT_PWM = 1'b0,
        TGT_REG = 1'b1
    } target_e;

    typedef enum logic [1:0] {
        CMP_CNT_PWM = 2'd0,
        CMP_CNT_REG = 2'd1,
        CMP_PWM_REG = 2'd2,
        CMP_NONE    = 2'd3
    } cmp_args_e;
endpackage

// state | meaning
// IDLE  | disabled; PC, counter and flag held at 0
// RUN   | execute the fetched instruction every cycle
// WAIT  | stalled until the end of the next counter period
// HALT  | stopped; counter and PWM keep running until en_i drops
module ppwm_core
    import ppwm_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    output logic [AW-1:0] instr_addr_o,
    input  logic [7:0]    instr_i,
    output logic          pwm_o,
    output logic          period_o,
    output logic          halted_o,
    output logic [W-1:0]  pwm_val_o,
    output logic [W-1:0]  reg_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    state_e        state;
    logic [AW-1:0] pc;
    logic [W-1:0]  cnt;
    logic [W-1:0]  pwm_q;
    logic [W-1:0]  reg_q;
    logic [W-1:0]  duty;
    logic          flag;

    command_e         cmd;
    target_e          tgt;
    logic [3:0]       arg;
    logic signed [3:0] arg_s;
    logic             wrap;

    assign cmd   = command_e'(instr_i[7:5]);
    assign tgt   = target_e'(instr_i[4]);
    assign arg   = instr_i[3:0];
    assign arg_s = instr_i[3:0];
    assign wrap  = (cnt == {W{1'b1}});

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_rel;
    assign pc_inc = pc + AW'(1);
    assign pc_rel = pc + AW'(arg_s);

    logic [W-1:0] tgt_val;
    assign tgt_val = (tgt == TGT_REG) ? reg_q : pwm_q;

    // Saturating add of a signed nibble, done as separate up/down paths
    logic [W:0] arith_up;
    logic [W:0] arith_dn;
    assign arith_up = {1'b0, tgt_val} + (W+1)'(arg);
    assign arith_dn = {1'b0, tgt_val} - (W+1)'(5'd16 - {1'b0, arg});

    logic [W-1:0] alu_res;
    logic         alu_wr;

    always_comb begin
        alu_res = tgt_val;
        alu_wr  = 1'b0;
        case (cmd)
            CMD_SET: begin
                alu_res = W'(arg) << (W - 4);
                alu_wr  = 1'b1;
            end
            CMD_ARITH: begin
                if (arg[3])
                    alu_res = arith_dn[W] ? '0 : arith_dn[W-1:0];
                else
                    alu_res = arith_up[W] ? '1 : arith_up[W-1:0];
                alu_wr = 1'b1;
            end
            CMD_SHIFT: begin
                alu_res = arg[3] ? (tgt_val >> arg[2:0]) : (tgt_val << arg[2:0]);
                alu_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic         cmp_res;

    always_comb begin
        cmp_a = cnt;
        cmp_b = pwm_q;
        case (cmp_args_e'(arg[1:0]))
            CMP_CNT_PWM: begin cmp_a = cnt;   cmp_b = pwm_q; end
            CMP_CNT_REG: begin cmp_a = cnt;   cmp_b = reg_q; end
            CMP_PWM_REG: begin cmp_a = pwm_q; cmp_b = reg_q; end
            default:     ;
        endcase
        case (arg[3:2])
            2'b00:   cmp_res = (cmp_a == cmp_b);
            2'b01:   cmp_res = (cmp_a <  cmp_b);
            2'b10:   cmp_res = (cmp_a >  cmp_b);
            default: cmp_res = (cmp_a != cmp_b);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
            pc    <= '0;
            cnt   <= '0;
            pwm_q <= '0;
            reg_q <= '0;
            duty  <= '0;
            flag  <= 1'b0;
        end else if (!en_i) begin
            state <= ST_IDLE;
            pc    <= '0;
            cnt   <= '0;
            flag  <= 1'b0;
        end else begin
            // Shadow sees the pre-instruction PWM value (non-blocking read)
            if (wrap)
                duty <= pwm_q;
            cnt <= (state == ST_IDLE) ? '0 : cnt + W'(1);

            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_RUN: begin
                    pc <= pc_inc;
                    if (alu_wr) begin
                        if (tgt == TGT_REG)
                            reg_q <= alu_res;
                        else
                            pwm_q <= alu_res;
                    end
                    case (cmd)
                        CMD_CTRL: begin
                            case (arg[1:0])
                                2'b01: begin
                                    pc    <= pc;
                                    state <= ST_HALT;
                                end
                                2'b10:   state <= ST_WAIT;
                                2'b11:   pc    <= '0;
                                default: ;
                            endcase
                        end
                        CMD_JUMP:   pc <= pc_rel;
                        CMD_BRANCH: if (flag) pc <= pc_rel;
                        CMD_CMP: begin
                            if (cmp_args_e'(arg[1:0]) != CMP_NONE)
                                flag <= cmp_res;
                        end
                        default: ;
                    endcase
                end
                ST_WAIT: if (wrap) state <= ST_RUN;
                ST_HALT: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign instr_addr_o = pc;
    assign period_o     = wrap;
    assign halted_o     = (state == ST_HALT);
    assign pwm_o        = (state != ST_IDLE) && (cnt < duty);
    assign pwm_val_o    = duty;
    assign reg_o        = reg_q;

endmodule

// File: tb/tb_ppwm_core.sv
// Bench for ppwm_core: directed programs plus random programs, all checked
// every cycle against an arithmetic model of the instruction semantics.
module tb_ppwm_core;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int MAXV = 255;
    localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [7:0]    prog [16];
    logic [7:0]    instr;
    logic [AW-1:0] addr;
    logic          pwm, period, halted;
    logic [W-1:0]  pwm_val, reg_v;

    always #5 clk = ~clk;
    assign instr = prog[addr];

    ppwm_core #(.W(W), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .instr_addr_o(addr), .instr_i(instr),
        .pwm_o(pwm), .period_o(period), .halted_o(halted),
        .pwm_val_o(pwm_val), .reg_o(reg_v)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_mode, m_pc, m_cnt, m_pwm, m_reg, m_flag, m_duty;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int a);
        return (a >= 8) ? a - 16 : a;
    endfunction

    task automatic execute();
        int ins, cmd, tr, a, s, t, v, npc, sel, c, op_a, op_b;
        bit wr;
        ins = int'(prog[m_pc]);
        cmd = ins / 32;
        tr  = (ins / 16) % 2;
        a   = ins % 16;
        s   = sx(a);
        t   = tr ? m_reg : m_pwm;
        v   = t;
        wr  = 0;
        npc = (m_pc + 1) % 16;
        case (cmd)
            0: case (a % 4)
                   1: begin npc = m_pc; m_mode = M_HALT; end
                   2: m_mode = M_WAIT;
                   3: npc = 0;
                   default: ;
               endcase
            1: begin v = a * 16; wr = 1; end
            2: begin
                v = t + s;
                if (v < 0) v = 0;
                if (v > MAXV) v = MAXV;
                wr = 1;
            end
            3: begin
                if (a >= 8) v = t / (1 << (a % 8));
                else        v = (t * (1 << (a % 8))) % 256;
                wr = 1;
            end
            5: npc = (m_pc + s + 16) % 16;
            6: begin
                sel = a % 4;
                c   = a / 4;
                if (sel != 3) begin
                    op_a = (sel == 2) ? m_pwm : m_cnt;
                    op_b = (sel == 0) ? m_pwm : m_reg;
                    case (c)
                        0: m_flag = int'(op_a == op_b);
                        1: m_flag = int'(op_a <  op_b);
                        2: m_flag = int'(op_a >  op_b);
                        default: m_flag = int'(op_a != op_b);
                    endcase
                end
            end
            7: if (m_flag != 0) npc = (m_pc + s + 16) % 16;
            default: ;
        endcase
        if (wr) begin
            if (tr != 0) m_reg = v;
            else         m_pwm = v;
        end
        m_pc = npc;
    endtask

    task automatic model_step();
        int old_pwm;
        bit per;
        if (!rst_n) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_pwm = 0;
            m_reg = 0; m_flag = 0; m_duty = 0;
        end else if (!en) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_flag = 0;
        end else begin
            per     = (m_cnt == MAXV);
            old_pwm = m_pwm;
            case (m_mode)
                M_IDLE: m_mode = M_RUN;
                M_RUN:  execute();
                M_WAIT: if (per) m_mode = M_RUN;
                default: ;
            endcase
            if (per) m_duty = old_pwm;
            m_cnt = (m_mode == M_IDLE) ? 0 : (m_cnt + 1) % 256;
        end
    endtask

    // Advance model and DUT by one clock, then compare every output.
    task automatic cycle();
        bit was_idle;
        was_idle = (m_mode == M_IDLE);
        model_step();
        if (was_idle && rst_n && en) m_cnt = 0;
        @(posedge clk);
        #1;
        check("instr_addr", int'(addr), m_pc);
        check("pwm_o", int'(pwm), int'(m_mode != M_IDLE && m_cnt < m_duty));
        check("period_o", int'(period), int'(m_cnt == MAXV));
        check("halted_o", int'(halted), int'(m_mode == M_HALT));
        check("pwm_val_o", int'(pwm_val), m_duty);
        check("reg_o", int'(reg_v), m_reg);
    endtask

    task automatic restart();
        en = 1'b0;
        cycle();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic go();
        en = 1'b1;
        cycle();
    endtask

    initial begin
        int hi, per;
        bit saw;
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_pwm = 0;
        m_reg = 0; m_flag = 0; m_duty = 0;

        // Reset and disabled idling
        repeat (3) cycle();
        rst_n = 1'b1;
        saw = 0;
        repeat (300) begin
            cycle();
            if (period) saw = 1;
        end
        check("rst_period_never", int'(saw), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_pwm_val", int'(pwm_val), 0);
        check("rst_pwm_o", int'(pwm), 0);

        // SET PWM 8; WAIT; JUMP -1
        prog[0] = 8'h28; prog[1] = 8'h02; prog[2] = 8'hAF;
        go();
        repeat (300) cycle();
        check("progA_duty", int'(pwm_val), 128);
        hi = 0; per = 0;
        repeat (512) begin
            cycle();
            hi  += int'(pwm);
            per += int'(period);
        end
        check("progA_high_cycles", hi, 256);
        check("progA_periods", per, 2);

        // REG saturation, then PWM floor at 0
        restart();
        prog[0] = 8'h3F; prog[1] = 8'h57; prog[2] = 8'h57; prog[3] = 8'h57;
        prog[4] = 8'h20; prog[5] = 8'h48; prog[6] = 8'h01;
        go();
        cycle(); check("sat_reg0", int'(reg_v), 8'hF0);
        cycle(); check("sat_reg1", int'(reg_v), 8'hF7);
        cycle(); check("sat_reg2", int'(reg_v), 8'hFE);
        cycle(); check("sat_reg3", int'(reg_v), 8'hFF);
        repeat (300) cycle();
        check("sat_pwm_floor", int'(pwm_val), 0);

        // Shift right 3, then shift 0 leaves it unchanged
        restart();
        prog[0] = 8'h28; prog[1] = 8'h6B; prog[2] = 8'h60; prog[3] = 8'h01;
        go();
        repeat (300) cycle();
        check("shift_r3_s0", int'(pwm_val), 8'h10);

        // Shift right 3, then left 4 overflows to 0
        restart();
        prog[0] = 8'h28; prog[1] = 8'h6B; prog[2] = 8'h64; prog[3] = 8'h01;
        go();
        repeat (300) cycle();
        check("shift_l4_trunc", int'(pwm_val), 0);

        // Branch taken (eq) and not taken (ne)
        restart();
        prog[0] = 8'h33; prog[1] = 8'h23; prog[2] = 8'hC2; prog[3] = 8'hE3;
        prog[4] = 8'h01; prog[5] = 8'h01; prog[6] = 8'h01;
        go();
        repeat (4) cycle();
        check("branch_taken_pc", int'(addr), 6);
        restart();
        prog[0] = 8'h33; prog[1] = 8'h23; prog[2] = 8'hCE; prog[3] = 8'hE3;
        prog[4] = 8'h01; prog[5] = 8'h01; prog[6] = 8'h01;
        go();
        repeat (4) cycle();
        check("branch_not_taken_pc", int'(addr), 4);

        // HALT at PC 5, counter and pwm keep running, disable/re-enable
        restart();
        prog[0] = 8'h28; prog[5] = 8'h01;
        go();
        repeat (6) cycle();
        check("halt_flag", int'(halted), 1);
        check("halt_pc", int'(addr), 5);
        hi = 0; per = 0;
        repeat (300) begin
            cycle();
            hi  += int'(pwm);
            per += int'(period);
        end
        check("halt_pc_frozen", int'(addr), 5);
        check("halt_counter_runs", int'(per > 0), 1);
        check("halt_pwm_runs", int'(hi > 0), 1);
        en = 1'b0;
        cycle();
        check("dis_halted", int'(halted), 0);
        check("dis_pwm_o", int'(pwm), 0);
        en = 1'b1;
        cycle();
        check("reen_pc0", int'(addr), 0);
        cycle();
        check("reen_pc1", int'(addr), 1);

        // Random programs with occasional enable drops
        for (int r = 0; r < 15; r++) begin
            restart();
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            go();
            repeat (1000) begin
                en = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ppwm_core.md
# ppwm_core

Programmable PWM execution core. Each cycle it fetches one 8-bit instruction from an external program memory and executes it against a working duty register (PWM), a scratch register (REG) and a compare flag. It runs a free-running global counter and drives the PWM output from a shadowed duty value. It is the consumer of the command/target/compare encodings defined in `ppwm_pkg`, and sits between the program memory and the pad.

## Interface
- `W`, default 8: PWM/REG/counter width; must be ≥ 4.
- `AW`, default 4: program counter width; program depth is 2^AW.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `en_i` in 1: run enable.
- `instr_addr_o` out AW: program counter (PC).
- `instr_i` in 8: instruction at `instr_addr_o`, combinational read, valid in the same cycle.
- `pwm_o` out 1: PWM output.
- `period_o` out 1: high during the cycle in which the counter equals 2^W−1.
- `halted_o` out 1: core is in HALT.
- `pwm_val_o` out W: active (shadowed) duty.
- `reg_o` out W: REG contents, for debug.

## Operation
- Instruction fields: [7:5] command (`command_e`), [4] target (`target_e`: 0 = PWM, 1 = REG), [3:0] arg.
- `sext(arg)` is arg sign-extended as 4-bit two's complement.
- States:
  - IDLE: entered on reset or `en_i`=0.
  - RUN: execute one instruction per cycle.
  - WAIT: stalled until the next period end.
  - HALT: stopped until `en_i` drops.
- `en_i`=0, in any state: next state IDLE. PC, counter and flag are cleared to 0. PWM, REG and the active duty are retained.
- IDLE with `en_i`=1: go to RUN. No instruction is executed in the IDLE cycle.
- Commands executed in RUN (PC advances to PC+1 unless stated):
  - CTRL, arg[1:0]:
    - 00: NOP.
    - 01: HALT; PC is not advanced.
    - 10: WAIT; PC advances.
    - 11: RESTART; PC ← 0.
  - SET: target ← arg << (W−4).
  - ARITH: target ← target + sext(arg), unsigned and saturating to the range [0, 2^W−1].
  - SHIFT: arg[3]=0 shifts left, 1 shifts right. arg[2:0] is the amount. Logical shift, zero fill, shift amount 0 leaves the target unchanged.
  - RSRV: NOP.
  - JUMP: PC ← PC + sext(arg), modulo 2^AW. Offset 0 spins on the same instruction.
  - CMP: flag ← (A cond B), unsigned comparison.
    - Operand select arg[1:0] (`cmp_args_e`): 00 = counter vs PWM, 01 = counter vs REG, 10 = PWM vs REG, 11 = flag unchanged.
    - Condition arg[3:2]: 00 eq, 01 lt, 10 gt, 11 ne.
    - The counter operand is its value in the executing cycle.
  - BRANCH: if flag, PC ← PC + sext(arg), modulo 2^AW; otherwise PC+1.
- WAIT: leaves WAIT for RUN at the clock edge that ends the first cycle with `period_o`=1 that occurs while already in WAIT. If WAIT executes during a wrap cycle, the core waits a full period.
- HALT: no fetch or execution; PC frozen. Counter and PWM output keep running. Exit only via `en_i`=0.
- Counter: increments every cycle in RUN, WAIT and HALT, and wraps from 2^W−1 to 0. Held at 0 in IDLE.
- Shadow: at the edge ending a cycle with `period_o`=1, active duty ← PWM value from before that cycle's instruction.
- `pwm_o` = (state ≠ IDLE) && (counter < active duty). Combinational from flops only.

## Timing
- Reset values: PC, counter, PWM, REG, flag and active duty are 0; state IDLE. All outputs are 0.
- The instruction presented in cycle n is executed; its results are visible in cycle n+1, including `instr_addr_o`.
- `halted_o` and `instr_addr_o` change on the edge after the decision that changes them.
- Duty changes take effect only at the period boundary: latency from SET to `pwm_val_o` is ≤ 2^W cycles.
- `en_i` deasserted mid-WAIT or mid-HALT: IDLE on the next edge. Re-enable restarts from PC 0 with the flag cleared.
- Write to PWM in the wrap cycle: the shadow takes the old PWM value. The new value is picked up at the following boundary.

## Test plan
- Reset with `en_i`=0 for 300 cycles → all outputs 0, `instr_addr_o`=0, `period_o` never pulses.
- Program 0x28, 0x02, 0xAF (SET PWM 8; WAIT; JUMP −1), W=8 → `pwm_val_o` becomes 0x80 after the first wrap; then `pwm_o` is high for 128 of every 256 cycles and `period_o` pulses every 256 cycles.
- REG saturation: 0x3F, then 0x57 ×3 → `reg_o` reads 0xF0, 0xF7, 0xFE, 0xFF. Then PWM=0 and 0x48 (ARITH −8) → PWM stays 0.
- Shift: PWM=0x80, then 0x6B → 0x10; then 0x64 → 0x00 (overflow truncated). Then 0x60 → unchanged.
- Branch: SET REG 3 (0x33) and SET PWM 3 (0x23) give REG=PWM=0x30. At PC 2, 0xC2 (CMP eq PWM/REG) then 0xE3 at PC 3 → next PC 6. With 0xCE (ne) instead → next PC 4.
- HALT 0x01 at PC 5 → `halted_o`=1 next cycle, PC frozen at 5, counter and `pwm_o` continue. Drop `en_i` → `halted_o`=0, `pwm_o`=0. Re-enable → fetch resumes at PC 0.
